// File: rtl/mult_shift_add_pkg.sv
// Shared definitions for the shift-and-add multiplier slice.
//   MULT_WIDTH  operand/result width
//   MULT_CNT_W  iteration counter width; it must be wide enough to hold MULT_WIDTH
//   mult_state_e  controller state encoding
package mult_shift_add_pkg;

   localparam int MULT_WIDTH = 32;
   localparam int MULT_CNT_W = 6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } mult_state_e;

endpackage

// File: rtl/mult_shift_add_if.sv
// Start/ready handshake bundle between execute/stall logic and the multiplier.
//   ctrl_MULT       start pulse; the operands are captured on this edge
//   data_operandA   multiplicand, two's complement
//   data_operandB   multiplier, two's complement
//   data_result     low WIDTH bits of the signed product
//   data_exception  the product does not fit in signed WIDTH bits
//   data_resultRDY  one-cycle pulse; data_result and data_exception are valid while it is high
//   busy            high while the multiplier is iterating
// master: the requester (execute stage).  slave: the multiplier.
interface mult_shift_add_if
   import mult_shift_add_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
);
   logic             ctrl_MULT;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output ctrl_MULT, data_operandA, data_operandB,
      input  data_result, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  ctrl_MULT, data_operandA, data_operandB,
      output data_result, data_exception, data_resultRDY, busy
   );
endinterface

// File: rtl/mult_shift_add_iter_count.sv
// Iteration counter for the multiplier.
//   clock, reset  rising-edge clock; synchronous active-high reset
//   clr           returns the count to 0 (this has priority over en)
//   en            increments the count by one
//   tc            high while the count equals WIDTH-1, which is the last iteration
module mult_shift_add_iter_count #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);
   logic [CNT_W-1:0] count;

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

   assign tc = (count == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/mult_shift_add.sv
// Iterative signed shift-and-add multiplier. On each RUN cycle it makes one
// multiplicand shift and one conditional add.
//   clock, reset  rising-edge clock; synchronous active-high reset
//   bus           mult_shift_add_if slave (start/ready handshake and operands)
//
// state  | meaning
// S_IDLE | waiting for ctrl_MULT
// S_RUN  | WIDTH iterations over the operand magnitudes; busy is high
// S_DONE | sign/overflow fix-up; data_resultRDY is registered on this edge
//
// ctrl_MULT wins in every state. It recaptures the operands and restarts the
// iteration, so an aborted operation never produces a ready pulse. A start that
// arrives in S_DONE still lets the old result retire.
module mult_shift_add
   import mult_shift_add_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int CNT_W = MULT_CNT_W
) (
   input  logic            clock,
   input  logic            reset,
   mult_shift_add_if.slave bus
);
   // Largest product magnitudes that still fit: 2^(W-1) when the product is negative, 2^(W-1)-1 when it is positive.
   localparam logic [2*WIDTH-1:0] NEG_MAX = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [2*WIDTH-1:0] POS_MAX = NEG_MAX - {{(2*WIDTH-1){1'b0}}, 1'b1};

   mult_state_e        state;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic               sign_r;
   logic [WIDTH-1:0]   result_r;
   logic               exc_r;
   logic               rdy_r;
   logic               busy_r;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic               tc;

   // Negating -2^(W-1) gives the same bit pattern back. Read as an unsigned value, that pattern is 2^(W-1), which is the correct magnitude.
   assign mag_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
   assign mag_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

   mult_shift_add_iter_count #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter_count (
      .clock (clock),
      .reset (reset),
      .clr   (bus.ctrl_MULT),
      .en    (state == S_RUN),
      .tc    (tc)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         sign_r   <= 1'b0;
         result_r <= '0;
         exc_r    <= 1'b0;
         rdy_r    <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         rdy_r <= 1'b0;

         // Retire from the old acc/sign_r before a same-edge restart overwrites them.
         if (state == S_DONE) begin
            rdy_r    <= 1'b1;
            result_r <= sign_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            exc_r    <= acc > (sign_r ? NEG_MAX : POS_MAX);
         end

         if (bus.ctrl_MULT) begin
            sign_r <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            state  <= S_RUN;
            busy_r <= 1'b1;
         end else begin
            case (state)
               S_IDLE: state <= S_IDLE;
               S_RUN: begin
                  if (mplier[0]) begin
                     acc <= acc + mcand;
                  end
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  if (tc) begin
                     state  <= S_DONE;
                     busy_r <= 1'b0;
                  end
               end
               S_DONE:  state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.data_result    = result_r;
   assign bus.data_exception = exc_r;
   assign bus.data_resultRDY = rdy_r;
   assign bus.busy           = busy_r;
endmodule
